// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel line-buffer front end: default pixel
// width, 3x3 window slot indices and a packed window type.
package sobel_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned WIN_N     = 9;

  // Window slots, row-major from top-left; W_BR holds the newest pixel.
  localparam int unsigned W_TL = 0;
  localparam int unsigned W_TM = 1;
  localparam int unsigned W_TR = 2;
  localparam int unsigned W_ML = 3;
  localparam int unsigned W_MM = 4;
  localparam int unsigned W_MR = 5;
  localparam int unsigned W_BL = 6;
  localparam int unsigned W_BM = 7;
  localparam int unsigned W_BR = 8;

  // Packed 3x3 window at the default pixel width; slot k at bits k*PIX_W +: PIX_W.
  typedef logic [WIN_N-1:0][PIX_W_DEF-1:0] win_t;

endpackage

// File: rtl/sobel_row_mem.sv
// One image row of pixel storage: asynchronous read, synchronous write.
// Contents are not reset; the owner's counters decide when they are meaningful.
module sobel_row_mem
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = PIX_W_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming pixel at the current column
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Combinational read of the same column, seen before this cycle's write
  always_comb begin
    rdata = mem_q[addr];
  end

endmodule

// File: rtl/sobel_line_buffer.sv
// Pixel-stream front end of the Sobel pipeline. Keeps the two previous rows
// in row memories and shifts a 3x3 neighbourhood one column per accepted pixel.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64,
  parameter int unsigned PIX_W      = PIX_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_lb,
  input  logic                 enable_conv,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_in,
  output logic                 pix_ready,
  output logic [9*PIX_W-1:0]   win_out,
  output logic                 win_valid,
  output logic                 buffer_full,
  output logic                 frame_end
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic             accept;
  logic             col_last;
  logic             row_last;
  logic [PIX_W-1:0] top_rd;
  logic [PIX_W-1:0] mid_rd;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PIX_W-1:0] win_q [WIN_N];
  logic [PIX_W-1:0] win_d [WIN_N];
  logic             win_valid_q, win_valid_d;
  logic             buffer_full_q, buffer_full_d;
  logic             frame_end_q, frame_end_d;

  // mem0 holds row-2, mem1 holds row-1; mem1's old value ages into mem0
  sobel_row_mem #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W),
    .AW    (COL_W)
  ) u_mem0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (mid_rd),
    .rdata (top_rd)
  );

  sobel_row_mem #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W),
    .AW    (COL_W)
  ) u_mem1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (pix_in),
    .rdata (mid_rd)
  );

  // Handshake and position decode
  always_comb begin
    pix_ready = enable_lb | enable_conv;
    accept    = pix_valid & pix_ready;
    col_last  = (col_q == COL_LAST);
    row_last  = (row_q == ROW_LAST);
  end

  // Raster position: column wraps into the next row, last row wraps to the frame start
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Shift the window left; the new right column is {row-2, row-1, incoming}
  always_comb begin
    for (int unsigned k = 0; k < WIN_N; k++) begin
      win_d[k] = win_q[k];
    end
    if (accept) begin
      win_d[W_TL] = win_q[W_TM];
      win_d[W_TM] = win_q[W_TR];
      win_d[W_TR] = top_rd;
      win_d[W_ML] = win_q[W_MM];
      win_d[W_MM] = win_q[W_MR];
      win_d[W_MR] = mid_rd;
      win_d[W_BL] = win_q[W_BM];
      win_d[W_BM] = win_q[W_BR];
      win_d[W_BR] = pix_in;
    end
  end

  // Status flags; a frame wrap clears buffer_full even if it would also set it
  always_comb begin
    win_valid_d   = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    frame_end_d   = accept && col_last && row_last;
    buffer_full_d = buffer_full_q;
    if (frame_end_d) begin
      buffer_full_d = 1'b0;
    end else if (accept && (row_q == ROW_TWO) && (col_q == COL_TWO)) begin
      buffer_full_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q         <= '0;
      row_q         <= '0;
      win_valid_q   <= 1'b0;
      buffer_full_q <= 1'b0;
      frame_end_q   <= 1'b0;
      for (int unsigned k = 0; k < WIN_N; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      win_valid_q   <= win_valid_d;
      buffer_full_q <= buffer_full_d;
      frame_end_q   <= frame_end_d;
      for (int unsigned k = 0; k < WIN_N; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  // Drive outputs from registered state
  always_comb begin
    win_valid   = win_valid_q;
    buffer_full = buffer_full_q;
    frame_end   = frame_end_q;
    for (int unsigned k = 0; k < WIN_N; k++) begin
      win_out[k*PIX_W +: PIX_W] = win_q[k];
    end
  end

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Scoreboard bench for sobel_line_buffer on a 4x4 image with pixel = row*16+col.
module tb_sobel_line_buffer;
  import sobel_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable_lb;
  logic          enable_conv;
  logic          pix_valid;
  logic [PW-1:0] pix_in;
  logic          pix_ready;
  logic [71:0]   win_out;
  logic          win_valid;
  logic          buffer_full;
  logic          frame_end;

  int checks = 0;
  int errors = 0;
  int br = 0;
  int bc = 0;

  typedef struct {
    win_t win;
    logic full;
    logic fend;
  } exp_t;

  exp_t sb[$];

  logic [71:0] fill_win;
  logic [71:0] snap_win;
  logic        snap_full;

  always #5 clk = ~clk;

  sobel_line_buffer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable_lb   (enable_lb),
    .enable_conv (enable_conv),
    .pix_valid   (pix_valid),
    .pix_in      (pix_in),
    .pix_ready   (pix_ready),
    .win_out     (win_out),
    .win_valid   (win_valid),
    .buffer_full (buffer_full),
    .frame_end   (frame_end)
  );

  function automatic win_t model_win(input int r, input int c);
    win_t w;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[3*i+j] = 8'((r - 2 + i) * 16 + (c - 2 + j));
      end
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Present the next raster pixel for one accepting cycle; outputs are visible on return
  task automatic send();
    exp_t e;
    pix_valid = 1'b1;
    pix_in    = 8'(br * 16 + bc);
    if (br >= 2 && bc >= 2) begin
      e.win  = model_win(br, bc);
      e.fend = (br == int'(H) - 1) && (bc == int'(W) - 1);
      e.full = !e.fend;
      sb.push_back(e);
    end
    if (bc == int'(W) - 1) begin
      bc = 0;
      br = (br == int'(H) - 1) ? 0 : br + 1;
    end else begin
      bc = bc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented window is matched against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (win_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: got window %h expected none", win_out);
        end else begin
          e = sb.pop_front();
          check("mon_win", win_out, e.win);
          check("mon_full", {71'd0, buffer_full}, {71'd0, e.full});
          check("mon_fend", {71'd0, frame_end}, {71'd0, e.fend});
        end
      end else if (frame_end) begin
        checks++;
        errors++;
        $display("FAIL mon_fend_alone: got frame_end 1 expected 0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fill_win    = {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0};
    reset       = 1'b1;
    enable_lb   = 1'b0;
    enable_conv = 1'b0;
    pix_valid   = 1'b0;
    pix_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_win", win_out, '0);
    check("rst_valid", {71'd0, win_valid}, 72'd0);
    check("rst_full", {71'd0, buffer_full}, 72'd0);
    check("rst_fend", {71'd0, frame_end}, 72'd0);
    reset     = 1'b0;
    enable_lb = 1'b1;

    // Fill up to the first complete window
    repeat (10) send();
    check("fill_pre_full", {71'd0, buffer_full}, 72'd0);
    send();
    check("fill_full", {71'd0, buffer_full}, 72'd1);
    check("fill_valid", {71'd0, win_valid}, 72'd1);
    check("fill_win", win_out, fill_win);

    // Row wrap: (2,3) valid, (3,0) and (3,1) not
    send();
    check("wrap_br", {64'd0, win_out[71:64]}, 72'd35);
    send();
    check("wrap_v30", {71'd0, win_valid}, 72'd0);
    send();
    check("wrap_v31", {71'd0, win_valid}, 72'd0);

    // Stall mid-row
    pix_valid = 1'b0;
    snap_win  = win_out;
    snap_full = buffer_full;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall_win", win_out, snap_win);
      check("stall_full", {71'd0, buffer_full}, {71'd0, snap_full});
      check("stall_valid", {71'd0, win_valid}, 72'd0);
    end

    // Disabled: valid pixel offered but not accepted
    enable_lb = 1'b0;
    pix_valid = 1'b1;
    pix_in    = 8'hAA;
    #1;
    check("dis_ready", {71'd0, pix_ready}, 72'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("dis_win", win_out, snap_win);
      check("dis_valid", {71'd0, win_valid}, 72'd0);
    end

    // Processing phase also accepts; resume at (3,2)
    enable_conv = 1'b1;
    #1;
    check("conv_ready", {71'd0, pix_ready}, 72'd1);
    send();
    enable_conv = 1'b0;
    enable_lb   = 1'b1;

    // Last pixel of the frame
    send();
    check("fe_pulse", {71'd0, frame_end}, 72'd1);
    check("fe_full", {71'd0, buffer_full}, 72'd0);
    check("fe_valid", {71'd0, win_valid}, 72'd1);
    check("fe_br", {64'd0, win_out[71:64]}, 72'd51);
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    check("fe_gone", {71'd0, frame_end}, 72'd0);

    // Second frame restarts at (0,0)
    repeat (16) send();
    check("f2_fend", {71'd0, frame_end}, 72'd1);

    // Reset mid-frame after six accepts, with a pixel still offered
    repeat (6) send();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_win", win_out, '0);
    check("mrst_valid", {71'd0, win_valid}, 72'd0);
    check("mrst_full", {71'd0, buffer_full}, 72'd0);
    check("mrst_fend", {71'd0, frame_end}, 72'd0);
    reset = 1'b0;
    br    = 0;
    bc    = 0;
    repeat (10) send();
    check("refill_pre_full", {71'd0, buffer_full}, 72'd0);
    send();
    check("refill_full", {71'd0, buffer_full}, 72'd1);
    check("refill_win", win_out, fill_win);
    repeat (5) send();
    pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 72'(sb.size()), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
